// File: rtl/joy_md_pkg.sv
// rtl/joy_md_pkg.sv - shared definitions for the Mega Drive pad responder
package joy_md_pkg;

  // Bit positions in the decoded, active-high button vector
  localparam int BTN_R     = 0;
  localparam int BTN_L     = 1;
  localparam int BTN_D     = 2;
  localparam int BTN_U     = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_X     = 7;
  localparam int BTN_Y     = 8;
  localparam int BTN_Z     = 9;
  localparam int BTN_START = 10;
  localparam int BTN_MODE  = 11;

  // DB9 data line positions on joy_out
  localparam int LN_D0 = 0;
  localparam int LN_D1 = 1;
  localparam int LN_D2 = 2;
  localparam int LN_D3 = 3;
  localparam int LN_TL = 4;
  localparam int LN_TR = 5;

  localparam logic [5:0] LINES_IDLE = 6'h3F;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_1,
    PH_2,
    PH_3,
    PH_4
  } md_phase_t;

endpackage

// File: rtl/joy_sync.sv
// rtl/joy_sync.sv - multi-flop synchronizer with a configurable reset value
module joy_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/joy_md_pad.sv
// rtl/joy_md_pad.sv - Mega Drive DB9 pad responder (3/6-button) driven by host TH select
module joy_md_pad #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TIMEOUT_US  = 1500,
  parameter int SIX_BUTTON  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] buttons,
  input  logic        joy_sel,
  output logic [5:0]  joy_out,
  output logic [2:0]  seq_phase
);
  import joy_md_pkg::*;

  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] T_MAX = TCW'(TIMEOUT_CYCLES);
  localparam md_phase_t PH_MAX = (SIX_BUTTON != 0) ? PH_4 : PH_2;

  logic            th;
  logic            th_prev_q, th_prev_d;
  logic [11:0]     btn_q, btn_d;
  logic [TCW-1:0]  tcnt_q, tcnt_d;
  md_phase_t       fcnt_q, fcnt_d;
  logic [5:0]      joy_out_q, joy_out_d;
  logic            th_fall, th_edge, expired;
  logic [5:0]      pull_low;

  joy_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (joy_sel),
    .q       (th)
  );

  always_comb begin
    th_prev_d = th;
    btn_d     = buttons;
    th_fall   = th_prev_q & ~th;
    th_edge   = th_prev_q ^ th;
    expired   = (tcnt_q == T_MAX);

    if (th_edge) begin
      tcnt_d = '0;
    end else if (expired) begin
      tcnt_d = tcnt_q;
    end else begin
      tcnt_d = tcnt_q + TCW'(1);
    end

    // An expired sequence restarts from idle, so a fall in the same cycle lands on PH_1
    fcnt_d = expired ? PH_IDLE : fcnt_q;
    if (th_fall && (fcnt_d != PH_MAX)) begin
      fcnt_d = md_phase_t'(fcnt_d + 3'd1);
    end
  end

  // pull_low marks lines driven low; the mux looks at the phase being entered this cycle
  always_comb begin
    pull_low = '0;
    if (th) begin
      pull_low[LN_TR] = btn_q[BTN_C];
      pull_low[LN_TL] = btn_q[BTN_B];
      if (fcnt_d == PH_3) begin
        pull_low[LN_D3] = btn_q[BTN_Z];
        pull_low[LN_D2] = btn_q[BTN_Y];
        pull_low[LN_D1] = btn_q[BTN_X];
        pull_low[LN_D0] = btn_q[BTN_MODE];
      end else begin
        pull_low[LN_D3] = btn_q[BTN_U];
        pull_low[LN_D2] = btn_q[BTN_D];
        pull_low[LN_D1] = btn_q[BTN_L];
        pull_low[LN_D0] = btn_q[BTN_R];
      end
    end else begin
      pull_low[LN_TR] = btn_q[BTN_START];
      pull_low[LN_TL] = btn_q[BTN_A];
      case (fcnt_d)
        PH_3: begin
          pull_low[LN_D3] = 1'b1;
          pull_low[LN_D2] = 1'b1;
          pull_low[LN_D1] = 1'b1;
          pull_low[LN_D0] = 1'b1;
        end
        PH_4: begin
          pull_low[LN_D3] = 1'b0;
          pull_low[LN_D2] = 1'b0;
          pull_low[LN_D1] = 1'b0;
          pull_low[LN_D0] = 1'b0;
        end
        default: begin
          pull_low[LN_D3] = btn_q[BTN_U];
          pull_low[LN_D2] = btn_q[BTN_D];
          pull_low[LN_D1] = 1'b1;
          pull_low[LN_D0] = 1'b1;
        end
      endcase
    end
    joy_out_d = ~pull_low;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      th_prev_q <= 1'b1;
      btn_q     <= '0;
      tcnt_q    <= '0;
      fcnt_q    <= PH_IDLE;
      joy_out_q <= LINES_IDLE;
    end else begin
      th_prev_q <= th_prev_d;
      btn_q     <= btn_d;
      tcnt_q    <= tcnt_d;
      fcnt_q    <= fcnt_d;
      joy_out_q <= joy_out_d;
    end
  end

  assign joy_out   = joy_out_q;
  assign seq_phase = fcnt_q;

endmodule

// File: tb/tb_joy_md_pad.sv
// tb/tb_joy_md_pad.sv - self-checking bench for joy_md_pad (6- and 3-button instances)
`timescale 1ns/1ps
module tb_joy_md_pad;

  localparam int CLK_HZ = 1_000_000;
  localparam int TO_US  = 40;
  localparam int TC     = CLK_HZ / 1_000_000 * TO_US;
  localparam int SYNC   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] buttons = '0;
  logic        joy_sel = 1'b1;
  logic [5:0]  out6, out3;
  logic [2:0]  ph6, ph3;

  int n_checks = 0;
  int n_errors = 0;

  joy_md_pad #(.CLK_FREQ_HZ(CLK_HZ), .TIMEOUT_US(TO_US), .SIX_BUTTON(1), .SYNC_STAGES(SYNC)) u_six (
    .clk(clk), .reset_n(rst_n), .buttons(buttons), .joy_sel(joy_sel), .joy_out(out6), .seq_phase(ph6));

  joy_md_pad #(.CLK_FREQ_HZ(CLK_HZ), .TIMEOUT_US(TO_US), .SIX_BUTTON(0), .SYNC_STAGES(SYNC)) u_three (
    .clk(clk), .reset_n(rst_n), .buttons(buttons), .joy_sel(joy_sel), .joy_out(out3), .seq_phase(ph3));

  always #500 clk = ~clk;

  initial begin
    #60_000_000;
    $display("FAIL watchdog: simulation still running after 60000 cycles");
    $fatal(1);
  end

  // Behavioural reference: pin delay queue, cycle stamp of last TH change, fall count per pad type
  bit          hist[$];
  bit          m_th_prev;
  int          cyc = 0;
  int          last_edge;
  logic [11:0] m_btn;
  int          m_phase [2];
  logic [5:0]  m_out [2];
  bit          model_valid = 0;
  int          cap [2] = '{4, 2};

  function automatic logic [5:0] lines(input bit th, input int ph, input logic [11:0] b);
    bit r = b[0], l = b[1], d = b[2], u = b[3], a = b[4], bb = b[5], c = b[6];
    bit x = b[7], y = b[8], z = b[9], st = b[10], md = b[11];
    if (th) begin
      if (ph == 3) return ~{c, bb, z, y, x, md};
      return ~{c, bb, u, d, l, r};
    end
    if (ph == 4) return {~st, ~a, 4'b1111};
    if (ph == 3) return {~st, ~a, 4'b0000};
    return {~st, ~a, ~u, ~d, 2'b00};
  endfunction

  task automatic model_step();
    bit th, fall, changed, expired;
    int p;
    if (!rst_n) begin
      hist = {};
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b1);
      m_th_prev = 1'b1;
      last_edge = cyc;
      m_btn = '0;
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = 0;
        m_out[k] = 6'h3F;
      end
      model_valid = 1;
    end else if (model_valid) begin
      th = hist[0];
      changed = (th != m_th_prev);
      fall = m_th_prev && !th;
      expired = (cyc - last_edge) > TC;
      for (int k = 0; k < 2; k++) begin
        p = expired ? 0 : m_phase[k];
        if (fall && p < cap[k]) p = p + 1;
        m_phase[k] = p;
        m_out[k] = lines(th, p, m_btn);
      end
      if (changed) last_edge = cyc;
      m_btn = buttons;
      m_th_prev = th;
      void'(hist.pop_front());
      hist.push_back(joy_sel);
    end
    cyc++;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (model_valid) begin
      chk("model_out6", {6'b0, out6}, {6'b0, m_out[0]});
      chk("model_ph6", {9'b0, ph6}, 12'(m_phase[0]));
      chk("model_out3", {6'b0, out3}, {6'b0, m_out[1]});
      chk("model_ph3", {9'b0, ph3}, 12'(m_phase[1]));
    end
  endtask

  task automatic hold(input logic s, input int n);
    joy_sel = s;
    repeat (n) cycle();
  endtask

  typedef struct {
    logic        sel;
    logic [11:0] btn;
    int          n;
    logic [5:0]  o6;
    logic [2:0]  p6;
    logic [5:0]  o3;
    logic [2:0]  p3;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [11:0] b, got;
    logic [5:0]  h0, l1, l3, h3;
    int          n;

    vecs[0]  = '{1'b1, 12'h011, 10, 6'h3E, 3'd0, 6'h3E, 3'd0};
    vecs[1]  = '{1'b0, 12'h011, 10, 6'h2C, 3'd1, 6'h2C, 3'd1};
    vecs[2]  = '{1'b1, 12'h280, 10, 6'h3F, 3'd1, 6'h3F, 3'd1};
    vecs[3]  = '{1'b0, 12'h280, 10, 6'h3C, 3'd2, 6'h3C, 3'd2};
    vecs[4]  = '{1'b1, 12'h280, 10, 6'h3F, 3'd2, 6'h3F, 3'd2};
    vecs[5]  = '{1'b0, 12'h280, 10, 6'h30, 3'd3, 6'h3C, 3'd2};
    vecs[6]  = '{1'b1, 12'h280, 10, 6'h35, 3'd3, 6'h3F, 3'd2};
    vecs[7]  = '{1'b0, 12'h280, 10, 6'h3F, 3'd4, 6'h3C, 3'd2};
    vecs[8]  = '{1'b1, 12'h280, 10, 6'h3F, 3'd4, 6'h3F, 3'd2};
    vecs[9]  = '{1'b1, 12'h280, TC + 10, 6'h3F, 3'd0, 6'h3F, 3'd0};
    vecs[10] = '{1'b0, 12'h280, 10, 6'h3C, 3'd1, 6'h3C, 3'd1};
    vecs[11] = '{1'b1, 12'h280, 10, 6'h3F, 3'd1, 6'h3F, 3'd1};
    vecs[12] = '{1'b0, 12'h280, 10, 6'h3C, 3'd2, 6'h3C, 3'd2};
    vecs[13] = '{1'b1, 12'h280, 10, 6'h3F, 3'd2, 6'h3F, 3'd2};
    vecs[14] = '{1'b0, 12'h280, 10, 6'h30, 3'd3, 6'h3C, 3'd2};
    vecs[15] = '{1'b1, 12'h280, 10, 6'h35, 3'd3, 6'h3F, 3'd2};

    rst_n = 1'b0;
    repeat (3) cycle();
    chk("reset_out6", {6'b0, out6}, 12'h03F);
    chk("reset_ph6", {9'b0, ph6}, 12'h000);
    chk("reset_out3", {6'b0, out3}, 12'h03F);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      buttons = vecs[i].btn;
      hold(vecs[i].sel, vecs[i].n);
      chk($sformatf("vec%0d_out6", i), {6'b0, out6}, {6'b0, vecs[i].o6});
      chk($sformatf("vec%0d_ph6", i), {9'b0, ph6}, {9'b0, vecs[i].p6});
      chk($sformatf("vec%0d_out3", i), {6'b0, out3}, {6'b0, vecs[i].o3});
      chk($sformatf("vec%0d_ph3", i), {9'b0, ph3}, {9'b0, vecs[i].p3});
    end

    // Reset in the middle of high3, then the first fall must count as 1
    rst_n = 1'b0;
    cycle();
    chk("midreset_out6", {6'b0, out6}, 12'h03F);
    chk("midreset_ph6", {9'b0, ph6}, 12'h000);
    rst_n = 1'b1;
    hold(1'b1, 5);
    hold(1'b0, 10);
    chk("postreset_ph6", {9'b0, ph6}, 12'h001);
    chk("postreset_out6", {6'b0, out6}, 12'h03C);

    // Select latency SYNC+1, buttons latency 2
    joy_sel = 1'b1;
    repeat (SYNC) cycle();
    chk("sel_lat_early", {6'b0, out6}, 12'h03C);
    cycle();
    chk("sel_lat_hit", {6'b0, out6}, 12'h03F);
    buttons = 12'h011;
    cycle();
    chk("btn_lat_early", {6'b0, out6}, 12'h03F);
    cycle();
    chk("btn_lat_hit", {6'b0, out6}, 12'h03E);

    // Loopback: a 6-button reader decodes the pad each frame
    for (int f = 0; f < 20; f++) begin
      b = 12'($urandom);
      buttons = b;
      hold(1'b1, TC + 10); h0 = out6;
      hold(1'b0, 6);       l1 = out6;
      hold(1'b1, 6);
      hold(1'b0, 6);
      hold(1'b1, 6);
      hold(1'b0, 6);       l3 = out6;
      hold(1'b1, 6);       h3 = out6;
      hold(1'b0, 6);
      hold(1'b1, 6);
      got = {~h3[0], ~l1[5], ~h3[3], ~h3[2], ~h3[1], ~h0[5], ~h0[4], ~l1[4],
             ~h0[3], ~h0[2], ~h0[1], ~h0[0]};
      chk("loopback_btn", got, b);
      chk("loopback_sig", {6'b0, l1[1:0], l3[3:0]}, 12'h000);
    end

    // Random TH toggling incl. sub-latency pulses, near-timeout gaps and resets
    for (int s = 0; s < 120; s++) begin
      buttons = 12'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
      end
      case ($urandom_range(0, 3))
        0:       n = int'($urandom_range(1, 3));
        1:       n = int'($urandom_range(TC - 1, TC + 3));
        default: n = int'($urandom_range(4, 20));
      endcase
      hold(~joy_sel, n);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
